// File: rtl/dyn_mem_addr_mapper.sv
// Runtime-reconfigurable byte-address to bank/offset mapper for the dynamic scratchpad.
// Mode changes stall new requests, drain in-flight traffic, then switch.
module dyn_mem_addr_mapper #(
  parameter int unsigned NumBanks       = 8,
  parameter int unsigned BankWords      = 1024,
  parameter int unsigned WordBytes      = 8,
  parameter int unsigned GranWords      = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned DefaultMap     = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  input  logic [1:0]                   cfg_map_i,
  output logic                         cfg_ready_o,
  output logic                         cfg_err_o,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic                         req_write_i,
  output logic                         bank_valid_o,
  input  logic                         bank_ready_i,
  output logic [$clog2(NumBanks)-1:0]  bank_idx_o,
  output logic [$clog2(BankWords)-1:0] bank_offset_o,
  output logic                         bank_write_o,
  input  logic                         rsp_valid_i,
  output logic [1:0]                   cur_map_o,
  output logic                         busy_o
);

  localparam int unsigned LB = $clog2(NumBanks);
  localparam int unsigned LO = $clog2(BankWords);
  localparam int unsigned LW = $clog2(WordBytes);
  localparam int unsigned LG = $clog2(GranWords);
  localparam int unsigned WA = LB + LO;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_e;
  typedef enum logic [1:0] {
    MAP_INTERLEAVE = 2'd0,
    MAP_NONE_INTER = 2'd1,
    MAP_PARTIAL    = 2'd2,
    MAP_ILLEGAL    = 2'd3
  } map_e;

  state_e        state, state_next;
  map_e          cur_map, pend_map;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [WA-1:0] word;
  logic [LB-1:0] dec_idx;
  logic [LO-1:0] dec_off;
  logic          accept, bank_fire, rsp_take;
  logic          unused_addr;

  assign word        = req_addr_i[LW +: WA];
  assign unused_addr = ^req_addr_i;

  always_comb begin
    dec_idx = word[LB-1:0];
    dec_off = word[WA-1:LB];
    case (cur_map)
      MAP_NONE_INTER: begin
        dec_idx = word[WA-1:WA-LB];
        dec_off = word[WA-LB-1:0];
      end
      MAP_PARTIAL: begin
        dec_idx = word[LG+LB-1:LG];
        dec_off = {word[WA-1:LG+LB], word[LG-1:0]};
      end
      default: ;
    endcase
  end

  // The held output register counts toward the limit so that at most
  // MaxOutstanding requests are ever issued without a completion.
  assign occupancy   = {1'b0, count} + (CW+1)'(bank_valid_o);
  assign bank_fire   = bank_valid_o && bank_ready_i;
  assign rsp_take    = rsp_valid_i && (count != '0);
  assign req_ready_o = (state == IDLE) && !cfg_valid_i
                    && (occupancy < (CW+1)'(MaxOutstanding))
                    && (!bank_valid_o || bank_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bank_valid_o  <= 1'b0;
      bank_idx_o    <= '0;
      bank_offset_o <= '0;
      bank_write_o  <= 1'b0;
      count         <= '0;
      state         <= IDLE;
      cur_map       <= map_e'(2'(DefaultMap));
      pend_map      <= MAP_INTERLEAVE;
    end else begin
      if (accept) begin
        bank_valid_o  <= 1'b1;
        bank_idx_o    <= dec_idx;
        bank_offset_o <= dec_off;
        bank_write_o  <= req_write_i;
      end else if (bank_fire) begin
        bank_valid_o  <= 1'b0;
      end
      case ({bank_fire, rsp_take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      state <= state_next;
      if (state == IDLE && cfg_valid_i) pend_map <= map_e'(cfg_map_i);
      if (state == SWITCH && pend_map != MAP_ILLEGAL) cur_map <= pend_map;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_valid_i) state_next = DRAIN;
      DRAIN:   if (count == '0 && !bank_valid_o) state_next = SWITCH;
      SWITCH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so an acknowledge never escapes while reset is asserted.
  assign cfg_ready_o = rst_ni && (state == SWITCH);
  assign cfg_err_o   = cfg_ready_o && (pend_map == MAP_ILLEGAL);
  assign busy_o      = (state != IDLE);
  assign cur_map_o   = cur_map;

endmodule
